// File: rtl/leg_mux16_rr_arbiter_if.sv
// Request/grant bundle between the 16 requesters and the round-robin arbiter
// that owns the 16-to-1 data mux select.
interface leg_mux16_rr_arbiter_if;
    logic [15:0] req;
    logic        sel_en;
    logic [3:0]  sel_addr;
    logic [15:0] grant;
    logic [3:0]  hold_cnt;

    modport master (
        input  req,
        output sel_en,
        output sel_addr,
        output grant,
        output hold_cnt
    );

    modport slave (
        output req,
        input  sel_en,
        input  sel_addr,
        input  grant,
        input  hold_cnt
    );
endinterface

// File: rtl/leg_mux16_rr_arbiter.sv
// Round-robin arbiter driving the enable and address of a 16-to-1 8-bit mux.
// Rotating priority pointer plus a bounded hold time keeps the sharing fair.
module leg_mux16_rr_arbiter #(
    parameter int    UUID     = 0,
    parameter string NAME     = "",
    parameter int    MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    leg_mux16_rr_arbiter_if.master bus
);

    if (UUID < 0 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_param
        $error("leg_mux16_rr_arbiter: MAX_HOLD must be 1..15 and UUID non-negative");
    end

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  owner_q, owner_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] grant_q, grant_d;
    logic        sel_en_q, sel_en_d;
    logic [15:0] others;
    logic [4:0]  win_idle;
    logic [4:0]  win_next;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 16.
    // Scanning downwards lets the lowest offset overwrite earlier hits.
    function automatic logic [4:0] find_first(input logic [15:0] r, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = start + 4'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        others   = bus.req & ~(16'b1 << owner_q);
        win_idle = find_first(bus.req, ptr_q);
        win_next = find_first(others, owner_q + 4'd1);

        case (state_q)
            IDLE: begin
                if (win_idle[4]) begin
                    state_d = GRANT;
                    owner_d = win_idle[3:0];
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    ptr_d = owner_q + 4'd1;
                    if (win_next[4]) begin
                        owner_d = win_next[3:0];
                        hold_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        hold_d  = 4'd0;
                    end
                end else if (hold_q == MAX_HOLD_C) begin
                    // Saturated owner keeps the mux only while nobody else waits.
                    if (win_next[4]) begin
                        ptr_d   = owner_q + 4'd1;
                        owner_d = win_next[3:0];
                        hold_d  = 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        sel_en_d = (state_d == GRANT);
        grant_d  = (state_d == GRANT) ? (16'b1 << owner_d) : 16'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
            sel_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            sel_en_q <= sel_en_d;
        end
    end

    assign bus.sel_en   = sel_en_q;
    assign bus.sel_addr = owner_q;
    assign bus.grant    = grant_q;
    assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_leg_mux16_rr_arbiter.sv
// Bench for leg_mux16_rr_arbiter: three instances (MAX_HOLD 4, 2, 1) share one
// request stream and are checked every cycle against a behavioural model.
module tb_leg_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [7:0]  dat [16];

    logic        sel_en_w   [3];
    logic [3:0]  sel_addr_w [3];
    logic [15:0] grant_w    [3];
    logic [3:0]  hold_w     [3];
    logic [7:0]  mux_w      [3];

    int total;
    int bad;

    // Reference state per instance; owner -1 means idle.
    int m_owner [3];
    int m_hold  [3];
    int m_ptr   [3];
    int m_addr  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            leg_mux16_rr_arbiter_if bus_if ();
            assign bus_if.req = req;
            leg_mux16_rr_arbiter #(
                .UUID     (gi),
                .NAME     ("arb"),
                .MAX_HOLD ((gi == 0) ? 4 : ((gi == 1) ? 2 : 1))
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus_if.master)
            );
            assign sel_en_w[gi]   = bus_if.sel_en;
            assign sel_addr_w[gi] = bus_if.sel_addr;
            assign grant_w[gi]    = bus_if.grant;
            assign hold_w[gi]     = bus_if.hold_cnt;
            // Combinational 16-to-1 data mux steered by the arbiter.
            assign mux_w[gi]      = bus_if.sel_en ? dat[bus_if.sel_addr] : 8'h00;
        end
    endgenerate

    function automatic int mh(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int winner(input logic [15:0] r, input int start, input int excl);
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (start + k) % 16;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_hold[i]  = 0;
            m_ptr[i]   = 0;
            m_addr[i]  = 0;
        end
    endtask

    task automatic model_step(input logic [15:0] r);
        for (int i = 0; i < 3; i++) begin
            int cur;
            int w;
            cur = m_owner[i];
            if (cur < 0) begin
                if (r != 16'h0) begin
                    m_owner[i] = winner(r, m_ptr[i], -1);
                    m_hold[i]  = 1;
                end
            end else begin
                w = winner(r, (cur + 1) % 16, cur);
                if (!r[cur]) begin
                    m_ptr[i] = (cur + 1) % 16;
                    if (w >= 0) begin
                        m_owner[i] = w;
                        m_hold[i]  = 1;
                    end else begin
                        m_owner[i] = -1;
                        m_hold[i]  = 0;
                    end
                end else if (m_hold[i] >= mh(i)) begin
                    if (w >= 0) begin
                        m_ptr[i]   = (cur + 1) % 16;
                        m_owner[i] = w;
                        m_hold[i]  = 1;
                    end
                end else begin
                    m_hold[i] = m_hold[i] + 1;
                end
            end
            if (m_owner[i] >= 0) m_addr[i] = m_owner[i];
        end
    endtask

    task automatic cmp(input string name, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=0x%0h expected=0x%0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            cmp("sel_en",   i, int'(sel_en_w[i]),   (m_owner[i] >= 0) ? 1 : 0);
            cmp("grant",    i, int'(grant_w[i]),    (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0);
            cmp("sel_addr", i, int'(sel_addr_w[i]), m_addr[i]);
            cmp("hold_cnt", i, int'(hold_w[i]),     m_hold[i]);
        end
    endtask

    // Apply a request vector for one edge, advance the model, check just after the edge.
    task automatic step(input logic [15:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all();
        $display("cyc req=%04h  a:%0d/%0d/%0d  b:%0d/%0d/%0d  c:%0d/%0d/%0d", r,
                 sel_en_w[0], sel_addr_w[0], hold_w[0],
                 sel_en_w[1], sel_addr_w[1], hold_w[1],
                 sel_en_w[2], sel_addr_w[2], hold_w[2]);
    endtask

    // Pull reset between edges, confirm the asynchronous clear, release on a falling edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("async_sel_en", 0, int'(sel_en_w[0]), 0);
        cmp("async_grant",  0, int'(grant_w[0]),  0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        req   = 16'h0;
        for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
        model_reset();

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(16'h0000);
            cmp("idle_sel_en", 0, int'(sel_en_w[0]), 0);
            cmp("idle_hold",   0, int'(hold_w[0]),   0);
        end

        // Single requester on D5
        for (int k = 0; k < 10; k++) begin
            step(16'h0020);
            cmp("single_grant", 0, int'(grant_w[0]),    32'h0020);
            cmp("single_addr",  0, int'(sel_addr_w[0]), 5);
            cmp("single_hold",  0, int'(hold_w[0]),     (k + 1 < 4) ? k + 1 : 4);
        end
        step(16'h0000);

        // Rotation with wrap 0 <-> 15 on the MAX_HOLD=2 instance
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            step(16'h8001);
            cmp("wrap_addr",   1, int'(sel_addr_w[1]), ((k / 2) % 2 == 1) ? 15 : 0);
            cmp("wrap_sel_en", 1, int'(sel_en_w[1]),   1);
        end

        // Early release: owner 3 drops while 9 waits
        pulse_reset();
        step(16'h0008);
        cmp("early_owner3", 0, int'(sel_addr_w[0]), 3);
        step(16'h0200);
        cmp("early_addr9", 0, int'(sel_addr_w[0]), 9);
        cmp("early_hold1", 0, int'(hold_w[0]),     1);
        step(16'h0000);
        cmp("early_idle",  0, int'(sel_en_w[0]),   0);

        // Full contention on the MAX_HOLD=1 instance
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            step(16'hFFFF);
            cmp("full_addr", 2, int'(sel_addr_w[2]), k % 16);
            cmp("full_mux",  2, int'(mux_w[2]),      int'(dat[k % 16]));
        end

        // Async reset mid-grant on owner 7
        pulse_reset();
        step(16'h0080);
        step(16'h0080);
        cmp("pre_rst_hold", 0, int'(hold_w[0]), 2);
        pulse_reset();
        step(16'h0080);
        cmp("post_rst_addr", 0, int'(sel_addr_w[0]), 7);
        cmp("post_rst_hold", 0, int'(hold_w[0]),     1);

        // Randomised traffic with sticky requests and occasional resets
        r = 16'h0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 63) == 0) pulse_reset();
            if ($urandom_range(0, 9) < 4) begin
                r = 16'($urandom) & 16'($urandom);
                if ($urandom_range(0, 7) == 0) r = 16'h0;
            end
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
